// File: rtl/pw_phase_shift_if.sv
// Phase-shift controller bus: the register-block target request, the MMCM handshake and status.
// The controller connects through the slave modport; the register block and MMCM side use master.
interface pw_phase_shift_if #(
   parameter int unsigned pPHASE_WIDTH = 10
);
   logic signed [pPHASE_WIDTH-1:0] target_phase;
   logic                           update;
   logic                           locked;
   logic                           psdone;
   logic                           psen;
   logic                           psincdec;
   logic signed [pPHASE_WIDTH-1:0] current_phase;
   logic                           busy;
   logic                           error;

   modport master (
      output target_phase, update, locked, psdone,
      input  psen, psincdec, current_phase, busy, error
   );

   modport slave (
      input  target_phase, update, locked, psdone,
      output psen, psincdec, current_phase, busy, error
   );
endinterface

// File: rtl/pw_phase_shift_ctrl.sv
// Walks the trigger-clock MMCM fine phase one psen step at a time until it matches the
// clamped target, with psdone timeout and lock-loss recovery.
module pw_phase_shift_ctrl #(
   parameter int unsigned pPHASE_WIDTH = 10,
   parameter int unsigned pMAX_STEPS   = 448,
   parameter int unsigned pTIMEOUT     = 255
) (
   input logic               cwusb_clk,
   input logic               reset_n,
   pw_phase_shift_if.slave   ps
);
   localparam int unsigned W     = pPHASE_WIDTH;
   localparam int unsigned CNT_W = $clog2(pTIMEOUT + 1);

   localparam logic signed [W-1:0]     MAX_POS     = W'(pMAX_STEPS);
   localparam logic signed [W-1:0]     MAX_NEG     = -MAX_POS;
   localparam logic        [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(pTIMEOUT);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      STEP      = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   state_t                  state_q,   state_n;
   logic signed [W-1:0]     target_q,  target_n;
   logic signed [W-1:0]     current_q, current_n;
   logic        [CNT_W-1:0] cnt_q,     cnt_n;
   logic                    psen_q,    psen_n;
   logic                    incdec_q,  incdec_n;
   logic                    error_q,   error_n;
   logic                    busy_q,    busy_n;
   logic signed [W-1:0]     clamped;

   always_ff @(posedge cwusb_clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         target_q  <= '0;
         current_q <= '0;
         cnt_q     <= '0;
         psen_q    <= 1'b0;
         incdec_q  <= 1'b0;
         error_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_n;
         target_q  <= target_n;
         current_q <= current_n;
         cnt_q     <= cnt_n;
         psen_q    <= psen_n;
         incdec_q  <= incdec_n;
         error_q   <= error_n;
         busy_q    <= busy_n;
      end
   end

   always_comb begin
      state_n   = state_q;
      target_n  = target_q;
      current_n = current_q;
      cnt_n     = cnt_q;
      psen_n    = 1'b0;
      incdec_n  = incdec_q;
      error_n   = error_q;
      clamped   = ps.target_phase;

      if (ps.target_phase > MAX_POS) begin
         clamped = MAX_POS;
      end else if (ps.target_phase < MAX_NEG) begin
         clamped = MAX_NEG;
      end

      case (state_q)
         IDLE: begin
            if (target_q > current_q) begin
               incdec_n = 1'b1;
               psen_n   = 1'b1;
               state_n  = STEP;
            end else if (target_q < current_q) begin
               incdec_n = 1'b0;
               psen_n   = 1'b1;
               state_n  = STEP;
            end
         end
         STEP: begin
            cnt_n   = '0;
            state_n = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (ps.psdone) begin
               current_n = incdec_q ? current_q + W'(1) : current_q - W'(1);
               state_n   = IDLE;
            end else begin
               cnt_n = cnt_q + CNT_W'(1);
               // Abandon the walk where it stands so busy drops and no retry is attempted.
               if (cnt_n == TIMEOUT_CNT) begin
                  error_n  = 1'b1;
                  target_n = current_q;
                  state_n  = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase

      // MMCM reset on lock loss returns it to zero phase; the target is kept for the rewalk.
      if (!ps.locked) begin
         current_n = '0;
         state_n   = IDLE;
         psen_n    = 1'b0;
      end

      if (ps.update) begin
         target_n = clamped;
         error_n  = 1'b0;
      end

      busy_n = (state_n != IDLE) || (target_n != current_n);
   end

   assign ps.psen          = psen_q;
   assign ps.psincdec      = incdec_q;
   assign ps.current_phase = current_q;
   assign ps.busy          = busy_q;
   assign ps.error         = error_q;
endmodule

// File: tb/tb_pw_phase_shift_ctrl.sv
// Scoreboard bench for pw_phase_shift_ctrl: directed walks push expected psen steps,
// a negedge monitor pops and checks each psen pulse; a psdone model answers 12 cycles after psen.
module tb_pw_phase_shift_ctrl;
   localparam int unsigned W    = 10;
   localparam int          MAXS = 448;
   localparam int          TMO  = 255;

   typedef struct packed {
      logic                dir;
      logic signed [W-1:0] ph;
   } step_t;

   logic  clk = 1'b0;
   logic  reset_n;
   logic  model_done = 1'b0;
   logic  tb_done    = 1'b0;
   logic  done_en    = 1'b1;
   logic  spacing_en = 1'b0;
   logic  prev_psen  = 1'b0;
   int    last_psen  = -1;
   int    cyc        = 0;
   int    n_checks   = 0;
   int    n_fail     = 0;
   step_t exp_q[$];
   step_t mon_e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pw_phase_shift_if #(.pPHASE_WIDTH(W)) ps ();

   pw_phase_shift_ctrl #(
      .pPHASE_WIDTH(W),
      .pMAX_STEPS  (MAXS),
      .pTIMEOUT    (TMO)
   ) dut (
      .cwusb_clk(clk),
      .reset_n  (reset_n),
      .ps       (ps)
   );

   assign ps.psdone = model_done | tb_done;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // MMCM psdone model: one-cycle pulse sampled 12 cycles after the psen cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (reset_n && ps.psen && done_en) begin
            repeat (12) @(negedge clk);
            if (ps.locked) model_done = 1'b1;
            @(negedge clk);
            model_done = 1'b0;
         end
      end
   end

   // Monitor: every psen pulse must match the next expected step.
   always @(negedge clk) begin
      if (!spacing_en) last_psen = -1;
      if (reset_n && ps.psen) begin
         chk("psen_single_cycle", int'(prev_psen), 0);
         if (exp_q.size() == 0) begin
            chk("unexpected_psen", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("psen_dir", int'(ps.psincdec), int'(mon_e.dir));
            chk("psen_phase", ps.current_phase, mon_e.ph);
         end
         if (spacing_en && last_psen >= 0) chk("psen_spacing", cyc - last_psen, 14);
         last_psen = cyc;
      end
      prev_psen = reset_n & ps.psen;
   end

   task automatic push_walk(input int from, input int to);
      step_t e;
      if (to > from) begin
         for (int p = from; p < to; p++) begin
            e.dir = 1'b1; e.ph = W'(p); exp_q.push_back(e);
         end
      end else begin
         for (int p = from; p > to; p--) begin
            e.dir = 1'b0; e.ph = W'(p); exp_q.push_back(e);
         end
      end
   endtask

   task automatic do_update(input int val);
      ps.target_phase = W'(val);
      ps.update       = 1'b1;
      @(negedge clk);
      ps.update       = 1'b0;
   endtask

   task automatic wait_cur(input int target, input int budget);
      int k = 0;
      while (ps.current_phase != W'(target) && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk("wait_phase", ps.current_phase, target);
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while (ps.busy && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk("wait_idle_busy", int'(ps.busy), 0);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_psen"},     int'(ps.psen),     0);
      chk({tag, "_psincdec"}, int'(ps.psincdec), 0);
      chk({tag, "_phase"},    ps.current_phase,  0);
      chk({tag, "_busy"},     int'(ps.busy),     0);
      chk({tag, "_error"},    int'(ps.error),    0);
   endtask

   task automatic walk(input string name, input int from, input int to, input int req);
      int steps = (to > from) ? to - from : from - to;
      push_walk(from, to);
      do_update(req);
      wait_idle(steps * 14 + 50);
      chk(name, ps.current_phase, to);
      chk({name, "_queue_empty"}, exp_q.size(), 0);
   endtask

   initial begin
      int k;
      reset_n         = 1'b0;
      ps.update       = 1'b0;
      ps.locked       = 1'b0;
      ps.target_phase = '0;

      // Reset with random inputs
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_zero("reset");
         ps.target_phase = W'($urandom);
         ps.update       = 1'($urandom_range(0, 1));
         ps.locked       = 1'($urandom_range(0, 1));
         tb_done         = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      reset_n         = 1'b1;
      ps.update       = 1'b0;
      ps.locked       = 1'b1;
      ps.target_phase = '0;
      tb_done         = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("post_reset");

      // Increment walk to +3
      spacing_en = 1'b1;
      push_walk(0, 3);
      do_update(3);
      chk("busy_after_update", int'(ps.busy), 1);
      @(negedge clk);
      chk("first_psen_latency", int'(ps.psen), 1);
      wait_cur(3, 3 * 14 + 20);
      chk("busy_at_target", int'(ps.busy), 0);
      chk("inc_queue_empty", exp_q.size(), 0);
      repeat (4) @(negedge clk);
      spacing_en = 1'b0;

      // Decrement and clamps
      walk("dec_final", 3, -2, -2);
      walk("clamp_pos", -2, MAXS, 500);
      walk("clamp_neg", MAXS, -MAXS, -512);
      walk("return_zero", -MAXS, 0, 0);

      // Lock loss mid-walk
      push_walk(0, 5);
      do_update(10);
      wait_cur(5, 5 * 14 + 20);
      ps.locked = 1'b0;
      @(negedge clk);
      chk("lock_loss_phase", ps.current_phase, 0);
      chk("lock_loss_psen", int'(ps.psen), 0);
      chk("lock_loss_busy", int'(ps.busy), 1);
      repeat (20) @(negedge clk);
      chk("lock_loss_queue", exp_q.size(), 0);
      push_walk(0, 10);
      ps.locked = 1'b1;
      wait_idle(10 * 14 + 50);
      chk("relock_final", ps.current_phase, 10);
      chk("relock_queue", exp_q.size(), 0);
      chk("relock_error", int'(ps.error), 0);
      walk("back_zero", 10, 0, 0);

      // Retarget while a step is pending
      push_walk(0, 3);
      push_walk(3, 0);
      do_update(8);
      wait_cur(2, 2 * 14 + 20);
      repeat (2) @(negedge clk);
      do_update(0);
      wait_idle(6 * 14 + 50);
      chk("retarget_final", ps.current_phase, 0);
      chk("retarget_queue", exp_q.size(), 0);
      tb_done = 1'b1;
      @(negedge clk);
      tb_done = 1'b0;
      @(negedge clk);
      chk("spurious_psdone_phase", ps.current_phase, 0);
      chk("spurious_psdone_busy", int'(ps.busy), 0);

      // psdone timeout
      done_en = 1'b0;
      push_walk(0, 1);
      do_update(1);
      k = 0;
      while (!ps.psen && k < 10) begin
         @(negedge clk);
         k++;
      end
      chk("timeout_psen_seen", int'(ps.psen), 1);
      k = 0;
      while (!ps.error && k < 400) begin
         @(negedge clk);
         k++;
      end
      chk("timeout_latency", k, TMO + 1);
      chk("timeout_error", int'(ps.error), 1);
      chk("timeout_busy", int'(ps.busy), 0);
      chk("timeout_phase", ps.current_phase, 0);
      repeat (20) @(negedge clk);
      chk("timeout_queue", exp_q.size(), 0);
      chk("timeout_error_sticky", int'(ps.error), 1);
      do_update(0);
      chk("error_cleared", int'(ps.error), 0);
      chk("error_cleared_busy", int'(ps.busy), 0);
      done_en = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation exceeded time limit, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1);
   end
endmodule
